// File: rtl/countdown_timer_if.sv
// Control strobes and BCD display/status outputs of the m:ss game countdown timer.
interface countdown_timer_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       add_bonus;
  logic [3:0] min_bcd;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       warning;
  logic       time_up;
  logic       expired;

  modport master (
    output tick, start, pause, add_bonus,
    input  min_bcd, sec_tens, sec_ones, running, warning, time_up, expired
  );

  modport slave (
    input  tick, start, pause, add_bonus,
    output min_bcd, sec_tens, sec_ones, running, warning, time_up, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD m:ss countdown driven by a one-second tick; IDLE/RUN/DONE FSM with bonus time and warning.
// All outputs registered: any tick/start/add_bonus is visible one cycle later; no backpressure.
module countdown_timer #(
  parameter int unsigned START_MIN = 2,
  parameter int unsigned START_SEC = 0,
  parameter int unsigned WARN_SEC  = 10,
  parameter int unsigned BONUS_SEC = 5
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  tmr
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [9:0]  START_TOT = 10'(START_MIN * 60 + START_SEC);
  localparam logic [9:0]  MAX_TOT   = 10'd599;
  localparam logic [11:0] START_BCD = {4'(START_MIN), 4'(START_SEC / 10), 4'(START_SEC % 10)};

  state_t     state;
  logic [3:0] min_q, tens_q, ones_q;
  logic       running_q, warning_q, time_up_q, expired_q;
  logic [9:0] total;
  logic [9:0] nxt_tot;
  logic [10:0] sum;
  logic       do_tick;

  function automatic logic [11:0] to_bcd(input logic [9:0] t);
    logic [9:0] m;
    logic [9:0] s;
    m = t / 10'd60;
    s = t - m * 10'd60;
    return {4'(m), 4'(s / 10'd10), 4'(s % 10'd10)};
  endfunction

  function automatic logic warn_of(input logic [9:0] t);
    return (t <= 10'(WARN_SEC)) && (t != 10'd0);
  endfunction

  // Work in binary seconds so tick and bonus combine in one step; clamp before re-encoding.
  always_comb begin
    total   = 10'(min_q) * 10'd60 + 10'(tens_q) * 10'd10 + 10'(ones_q);
    do_tick = tmr.tick & ~tmr.pause;
    sum     = {1'b0, total}
            + (tmr.add_bonus ? 11'(BONUS_SEC) : 11'd0)
            - (do_tick ? 11'd1 : 11'd0);
    nxt_tot = (sum > 11'(MAX_TOT)) ? MAX_TOT : sum[9:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= IDLE;
      {min_q, tens_q, ones_q}  <= START_BCD;
      running_q                <= 1'b0;
      warning_q                <= 1'b0;
      time_up_q                <= 1'b0;
      expired_q                <= 1'b0;
    end else begin
      time_up_q <= 1'b0;
      if (tmr.start) begin
        // Start wins in every state; a same-cycle tick or bonus is dropped.
        {min_q, tens_q, ones_q} <= START_BCD;
        if (START_TOT == 10'd0) begin
          state     <= DONE;
          running_q <= 1'b0;
          warning_q <= 1'b0;
          time_up_q <= 1'b1;
          expired_q <= 1'b1;
        end else begin
          state     <= RUN;
          running_q <= 1'b1;
          warning_q <= warn_of(START_TOT);
          expired_q <= 1'b0;
        end
      end else if (state == RUN && (do_tick || tmr.add_bonus)) begin
        {min_q, tens_q, ones_q} <= to_bcd(nxt_tot);
        if (nxt_tot == 10'd0) begin
          state     <= DONE;
          running_q <= 1'b0;
          warning_q <= 1'b0;
          time_up_q <= 1'b1;
          expired_q <= 1'b1;
        end else begin
          warning_q <= warn_of(nxt_tot);
        end
      end
    end
  end

  assign tmr.min_bcd  = min_q;
  assign tmr.sec_tens = tens_q;
  assign tmr.sec_ones = ones_q;
  assign tmr.running  = running_q;
  assign tmr.warning  = warning_q;
  assign tmr.time_up  = time_up_q;
  assign tmr.expired  = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: three instances (2:00, 0:10 and 0:00 reload values).
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_v [3];
  logic start_v [3];
  logic pause_v [3];
  logic bonus_v [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  countdown_timer_if ia ();
  countdown_timer_if ib ();
  countdown_timer_if ic ();

  assign ia.tick = tick_v[0];  assign ia.start = start_v[0];
  assign ia.pause = pause_v[0]; assign ia.add_bonus = bonus_v[0];
  assign ib.tick = tick_v[1];  assign ib.start = start_v[1];
  assign ib.pause = pause_v[1]; assign ib.add_bonus = bonus_v[1];
  assign ic.tick = tick_v[2];  assign ic.start = start_v[2];
  assign ic.pause = pause_v[2]; assign ic.add_bonus = bonus_v[2];

  countdown_timer dut_a (.clk(clk), .reset(reset), .tmr(ia));

  countdown_timer #(.START_MIN(0), .START_SEC(10), .WARN_SEC(10), .BONUS_SEC(5))
    dut_b (.clk(clk), .reset(reset), .tmr(ib));

  countdown_timer #(.START_MIN(0), .START_SEC(0), .WARN_SEC(10), .BONUS_SEC(5))
    dut_c (.clk(clk), .reset(reset), .tmr(ic));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int digits(input int k);
    case (k)
      0:       return int'({ia.min_bcd, ia.sec_tens, ia.sec_ones});
      1:       return int'({ib.min_bcd, ib.sec_tens, ib.sec_ones});
      default: return int'({ic.min_bcd, ic.sec_tens, ic.sec_ones});
    endcase
  endfunction

  // Flags packed as {running, warning, time_up, expired}.
  function automatic int flags(input int k);
    case (k)
      0:       return int'({ia.running, ia.warning, ia.time_up, ia.expired});
      1:       return int'({ib.running, ib.warning, ib.time_up, ib.expired});
      default: return int'({ic.running, ic.warning, ic.time_up, ic.expired});
    endcase
  endfunction

  // Drive one cycle of strobes on instance k; returns after the following negedge.
  task automatic cyc(input int k, input logic t, input logic s, input logic b);
    tick_v[k]  = t;
    start_v[k] = s;
    bonus_v[k] = b;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick_v[i]  = 1'b0;
      start_v[i] = 1'b0;
      bonus_v[i] = 1'b0;
    end
  endtask

  task automatic ticks(input int k, input int n);
    for (int i = 0; i < n; i++) cyc(k, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      tick_v[i] = 1'b0; start_v[i] = 1'b0; pause_v[i] = 1'b0; bonus_v[i] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    check("rst_a_dig", digits(0), 'h200);
    check("rst_a_flg", flags(0), 'b0000);
    check("rst_b_dig", digits(1), 'h010);
    check("rst_b_flg", flags(1), 'b0000);
    check("rst_c_dig", digits(2), 'h000);
    check("rst_c_flg", flags(2), 'b0000);

    // Instance B: IDLE ignores tick and bonus
    cyc(1, 1'b1, 1'b0, 1'b1);
    check("idle_b_dig", digits(1), 'h010);
    check("idle_b_flg", flags(1), 'b0000);

    // Instance B: start at 0:10 gives warning at once, count to expiry
    cyc(1, 1'b0, 1'b1, 1'b0);
    check("b_start_dig", digits(1), 'h010);
    check("b_start_flg", flags(1), 'b1100);
    ticks(1, 9);
    check("b_001_dig", digits(1), 'h001);
    check("b_001_flg", flags(1), 'b1100);
    cyc(1, 1'b1, 1'b0, 1'b0);
    check("b_000_dig", digits(1), 'h000);
    check("b_000_flg", flags(1), 'b0011);
    cyc(1, 1'b0, 1'b0, 1'b0);
    check("b_tu_once", flags(1), 'b0001);
    cyc(1, 1'b1, 1'b0, 1'b1);
    check("b_done_dig", digits(1), 'h000);
    check("b_done_flg", flags(1), 'b0001);

    // Instance B: restart, 0:10 -> 0:09 borrow, then 0:01 tick+bonus -> 0:05
    cyc(1, 1'b0, 1'b1, 1'b0);
    check("b_restart", digits(1), 'h010);
    cyc(1, 1'b1, 1'b0, 1'b0);
    check("b_009", digits(1), 'h009);
    ticks(1, 8);
    check("b_001b", digits(1), 'h001);
    cyc(1, 1'b1, 1'b0, 1'b1);
    check("b_simul_dig", digits(1), 'h005);
    check("b_simul_flg", flags(1), 'b1100);

    // Instance C: 0:00 reload goes straight to DONE
    cyc(2, 1'b0, 1'b1, 1'b0);
    check("c_start_dig", digits(2), 'h000);
    check("c_start_flg", flags(2), 'b0011);
    cyc(2, 1'b0, 1'b0, 1'b0);
    check("c_after_flg", flags(2), 'b0001);

    // Instance A: start, 3 ticks -> 1:57
    cyc(0, 1'b0, 1'b1, 1'b0);
    check("a_start_flg", flags(0), 'b1000);
    ticks(0, 3);
    check("a_157_dig", digits(0), 'h157);
    check("a_157_flg", flags(0), 'b1000);

    // Bonus accumulation and saturation at 9:59
    for (int i = 0; i < 96; i++) cyc(0, 1'b0, 1'b0, 1'b1);
    check("a_957", digits(0), 'h957);
    cyc(0, 1'b0, 1'b0, 1'b1);
    check("a_sat1", digits(0), 'h959);
    cyc(0, 1'b0, 1'b0, 1'b1);
    check("a_sat2", digits(0), 'h959);

    // Restart, borrow chain 1:00 -> 0:59
    cyc(0, 1'b0, 1'b1, 1'b0);
    check("a_reload", digits(0), 'h200);
    ticks(0, 60);
    check("a_100", digits(0), 'h100);
    cyc(0, 1'b1, 1'b0, 1'b0);
    check("a_059", digits(0), 'h059);

    // Pause: ticks ignored, bonus still applies
    cyc(0, 1'b1, 1'b0, 1'b0);
    check("a_058", digits(0), 'h058);
    pause_v[0] = 1'b1;
    ticks(0, 5);
    check("a_paused", digits(0), 'h058);
    check("a_paused_flg", flags(0), 'b1000);
    cyc(0, 1'b0, 1'b0, 1'b1);
    check("a_pause_bonus", digits(0), 'h103);
    pause_v[0] = 1'b0;
    cyc(0, 1'b1, 1'b0, 1'b0);
    check("a_102", digits(0), 'h102);

    // Mid-run restart with same-cycle tick
    ticks(0, 32);
    check("a_030", digits(0), 'h030);
    cyc(0, 1'b1, 1'b1, 1'b0);
    check("a_restart_dig", digits(0), 'h200);
    check("a_restart_flg", flags(0), 'b1000);

    // Warning threshold edge
    ticks(0, 109);
    check("a_011_dig", digits(0), 'h011);
    check("a_011_flg", flags(0), 'b1000);
    cyc(0, 1'b1, 1'b0, 1'b0);
    check("a_010_flg", flags(0), 'b1100);

    // Reset while running beats a simultaneous start
    start_v[0] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("a_rst_dig", digits(0), 'h200);
    check("a_rst_flg", flags(0), 'b0000);
    start_v[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("a_rst_hold", flags(0), 'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
